// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the sequence detector.
// Accepts WIDTH-bit words over valid/ready and shifts them out one bit per
// clock on serial_out, in MSB-first or LSB-first order. The line idles at 0.
// Optional feature macro: BIT_SERIALIZER_PARITY_EN appends one even-parity bit
// after the last data bit of every word.
//
// state  | meaning
// IDLE   | no word in flight, ready for a new word
// SHIFT  | data bits of the current word on serial_out
// PARITY | parity bit on serial_out (only with BIT_SERIALIZER_PARITY_EN)

module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef BIT_SERIALIZER_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sreg, sreg_n, sreg_shift;
  logic             so_n, sv_n, wd_n;
  logic             din_first, shift_first, accept, load;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             par, par_n;
`endif

  // Ready is a pure function of where we are in the word; it opens on the
  // final serial cycle so the next word follows without a bubble.
  always_comb begin
    din_ready = 1'b0;
    case (state)
      IDLE:    din_ready = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
      SHIFT:   din_ready = 1'b0;
      PARITY:  din_ready = 1'b1;
`else
      SHIFT:   din_ready = (cnt == LAST);
`endif
      default: din_ready = 1'b0;
    endcase
  end

  assign accept = din_valid & din_ready;

  // The shift register always holds the bit currently on the line at the
  // send end, so the next bit is taken from the shifted copy.
  always_comb begin
    if (MSB_FIRST) begin
      sreg_shift  = {sreg[WIDTH-2:0], 1'b0};
      din_first   = din[WIDTH-1];
      shift_first = sreg_shift[WIDTH-1];
    end else begin
      sreg_shift  = {1'b0, sreg[WIDTH-1:1]};
      din_first   = din[0];
      shift_first = sreg_shift[0];
    end
  end

  // Next state plus next values of the registered serial outputs.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sreg_n  = sreg;
    so_n    = 1'b0;
    sv_n    = 1'b0;
    wd_n    = 1'b0;
    load    = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
    par_n   = par;
`endif
    case (state)
      IDLE: begin
        load = accept;
      end
      SHIFT: begin
        if (cnt != LAST) begin
          cnt_n  = cnt + 1'b1;
          sreg_n = sreg_shift;
          so_n   = shift_first;
          sv_n   = 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
          wd_n   = 1'b0;
`else
          wd_n   = (cnt == PENULT);
`endif
        end else begin
`ifdef BIT_SERIALIZER_PARITY_EN
          state_n = PARITY;
          so_n    = par;
          sv_n    = 1'b1;
          wd_n    = 1'b1;
`else
          state_n = IDLE;
          cnt_n   = '0;
          load    = accept;
`endif
        end
      end
`ifdef BIT_SERIALIZER_PARITY_EN
      PARITY: begin
        state_n = IDLE;
        cnt_n   = '0;
        load    = accept;
      end
`endif
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
    if (load) begin
      state_n = SHIFT;
      cnt_n   = '0;
      sreg_n  = din;
      so_n    = din_first;
      sv_n    = 1'b1;
      wd_n    = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par_n   = ^din;
`endif
    end
  end

  // State, datapath and registered outputs; reset discards any partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      sreg         <= '0;
      serial_out   <= 1'b0;
      serial_valid <= 1'b0;
      busy         <= 1'b0;
      word_done    <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par          <= 1'b0;
`endif
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      sreg         <= sreg_n;
      serial_out   <= so_n;
      serial_valid <= sv_n;
      busy         <= (state_n != IDLE);
      word_done    <= wd_n;
`ifdef BIT_SERIALIZER_PARITY_EN
      par          <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: one MSB-first and one LSB-first
// instance (WIDTH=8), shared clock and reset.
module tb_bit_serializer;

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int L = 8 + PAR;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] din_a, din_b;
  logic       valid_a, valid_b;
  logic       rdy_a, so_a, sv_a, busy_a, wd_a;
  logic       rdy_b, so_b, sv_b, busy_b, wd_b;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .din(din_a), .din_valid(valid_a),
    .din_ready(rdy_a), .serial_out(so_a), .serial_valid(sv_a),
    .busy(busy_a), .word_done(wd_a)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .din(din_b), .din_valid(valid_b),
    .din_ready(rdy_b), .serial_out(so_b), .serial_valid(sv_b),
    .busy(busy_b), .word_done(wd_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit sel, input logic [7:0] w, input logic v);
    if (sel) begin din_b = w; valid_b = v; end
    else     begin din_a = w; valid_a = v; end
  endtask

  task automatic get(input bit sel, output logic so, output logic sv,
                     output logic wd, output logic rdy, output logic bsy);
    if (sel) begin so = so_b; sv = sv_b; wd = wd_b; rdy = rdy_b; bsy = busy_b; end
    else     begin so = so_a; sv = sv_a; wd = wd_a; rdy = rdy_a; bsy = busy_a; end
  endtask

  function automatic logic exp_bit(input logic [7:0] w, input int k, input bit msb);
    if (k == 8) return ^w;
    return msb ? w[7-k] : w[k];
  endfunction

  task automatic chk_idle(input bit sel, input string tag);
    logic so, sv, wd, rdy, bsy;
    get(sel, so, sv, wd, rdy, bsy);
    chk({tag, "_so"}, so, 1'b0);
    chk({tag, "_sv"}, sv, 1'b0);
    chk({tag, "_wd"}, wd, 1'b0);
    chk({tag, "_busy"}, bsy, 1'b0);
    chk({tag, "_rdy"}, rdy, 1'b1);
  endtask

  // Sends one word, or two back-to-back with valid held, and checks every
  // serial cycle plus the idle cycle afterwards.
  task automatic stream(input bit sel, input logic [7:0] w0, input logic [7:0] w1,
                        input bit two, input string tag);
    logic so, sv, wd, rdy, bsy;
    logic [7:0] w;
    set_in(sel, w0, 1'b1);
    tick();
    if (two) set_in(sel, w1, 1'b1);
    else     set_in(sel, ~w0, 1'b0);
    for (int k = 0; k < (two ? 2 : 1); k++) begin
      w = (k == 0) ? w0 : w1;
      for (int j = 0; j < L; j++) begin
        get(sel, so, sv, wd, rdy, bsy);
        chk($sformatf("%s_w%0d_b%0d_so", tag, k, j), so, exp_bit(w, j, !sel));
        chk($sformatf("%s_w%0d_b%0d_sv", tag, k, j), sv, 1'b1);
        chk($sformatf("%s_w%0d_b%0d_wd", tag, k, j), wd, j == L - 1);
        chk($sformatf("%s_w%0d_b%0d_rdy", tag, k, j), rdy, j == L - 1);
        chk($sformatf("%s_w%0d_b%0d_busy", tag, k, j), bsy, 1'b1);
        tick();
        if (two && k == 0 && j == L - 1) set_in(sel, ~w1, 1'b0);
      end
    end
    chk_idle(sel, {tag, "_after"});
  endtask

  initial begin
    reset = 1'b1;
    din_a = 8'h00; din_b = 8'h00;
    valid_a = 1'b0; valid_b = 1'b0;
    tick();
    valid_a = 1'b1;  // reset must dominate a pending word
    din_a = 8'hFF;
    tick();
    chk_idle(0, "reset_a");
    chk_idle(1, "reset_b");
    valid_a = 1'b0;
    reset = 1'b0;
    tick();
    chk_idle(0, "post_reset_a");

    // A5 MSB-first: 1,0,1,0,0,1,0,1 (parity 0 when enabled)
    stream(0, 8'hA5, 8'h00, 1'b0, "a5");
    // Back-to-back A5 then 3C with no bubble
    stream(0, 8'hA5, 8'h3C, 1'b1, "b2b");
    // LSB-first: 01 -> 1 then zeros; 80 -> zeros then 1
    stream(1, 8'h01, 8'h00, 1'b0, "lsb01");
    stream(1, 8'h80, 8'h00, 1'b0, "lsb80");
    // Parity vectors: 07 -> parity 1, 03 -> parity 0
    stream(0, 8'h07, 8'h00, 1'b0, "p07");
    stream(0, 8'h03, 8'h00, 1'b0, "p03");

    // Reset during the 4th bit of FF discards the word
    set_in(0, 8'hFF, 1'b1);
    tick();
    set_in(0, 8'h00, 1'b0);
    tick(); tick(); tick();
    chk("mid_bit4_so", so_a, 1'b1);
    chk("mid_bit4_sv", sv_a, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle(0, "mid_reset");
    tick();
    chk_idle(0, "mid_reset_next");
    stream(0, 8'h0F, 8'h00, 1'b0, "after_rst0f");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
